imem_fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/imem_fetch_ctrl_if.sv | 72 +++++++
 rtl/fetch_addr_xlate.sv | 26 ++
 rtl/imem_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the imem fetch controller.
// Holds the FSM state enum, the transaction owner enum and the map defaults.
package fetch_pkg;

    localparam logic [31:0] D_TEXT_BASE  = 32'h0040_0000;
    localparam int          D_DEPTH      = 1024;
    localparam int          D_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } fetch_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } fetch_owner_e;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, its two requesters and imem.
// slave: controller side. master: CPU, debug reader and imem side.
interface imem_fetch_ctrl_if;

    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_flush;
    logic        cpu_ack;
    logic        cpu_gnt;
    logic        cpu_valid;
    logic [31:0] cpu_inst;
    logic        cpu_fault;

    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic        dbg_gnt;
    logic        dbg_valid;
    logic [31:0] dbg_inst;
    logic        dbg_fault;

    logic [31:0] imem_inst;
    logic        imemsrc;
    logic [31:0] imem_pc;

    logic        busy;

    modport slave (
        input  cpu_req,
        input  cpu_addr,
        input  cpu_flush,
        input  cpu_ack,
        output cpu_gnt,
        output cpu_valid,
        output cpu_inst,
        output cpu_fault,
        input  dbg_req,
        input  dbg_addr,
        input  dbg_ack,
        output dbg_gnt,
        output dbg_valid,
        output dbg_inst,
        output dbg_fault,
        input  imem_inst,
        output imemsrc,
        output imem_pc,
        output busy
    );

    modport master (
        output cpu_req,
        output cpu_addr,
        output cpu_flush,
        output cpu_ack,
        input  cpu_gnt,
        input  cpu_valid,
        input  cpu_inst,
        input  cpu_fault,
        output dbg_req,
        output dbg_addr,
        output dbg_ack,
        input  dbg_gnt,
        input  dbg_valid,
        input  dbg_inst,
        input  dbg_fault,
        output imem_inst,
        input  imemsrc,
        input  imem_pc,
        input  busy
    );

endinterface

// File: rtl/fetch_addr_xlate.sv
// Byte address to imem word index translation with fault detection.
// Ports: addr (byte address) in; index (word index), fault out.
module fetch_addr_xlate
    import fetch_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = D_TEXT_BASE,
    parameter int          DEPTH     = D_DEPTH
) (
    input  logic [31:0] addr,
    output logic [31:0] index,
    output logic        fault
);

    logic [31:0] off;

    // Below-base addresses wrap to huge offsets; the explicit compare
    // keeps them faulting even if DEPTH is ever made very large.
    always_comb begin
        off   = addr - TEXT_BASE;
        index = off >> 2;
        fault = (addr[1:0] != 2'b00)
             || (addr < TEXT_BASE)
             || (index >= 32'(DEPTH));
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Arbiter/sequencer for the single imem read port (CPU and debug reader).
// Ports: clk, rst (sync, active-high), bus (imem_fetch_ctrl_if.slave).
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = D_TEXT_BASE,
    parameter int          DEPTH      = D_DEPTH,
    parameter int          STARVE_MAX = D_STARVE_MAX
) (
    input  logic            clk,
    input  logic            rst,
    imem_fetch_ctrl_if.slave bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    fetch_state_e  state;
    fetch_owner_e  owner;
    logic [SW-1:0] starve_cnt;

    logic        imemsrc_q;
    logic [31:0] imem_pc_q;
    logic        cpu_gnt_q;
    logic        dbg_gnt_q;
    logic        cpu_valid_q;
    logic        dbg_valid_q;
    logic        cpu_fault_q;
    logic        dbg_fault_q;

    logic        cpu_ok;
    logic        starved;
    logic        sel_dbg;
    logic        grant;
    logic [31:0] sel_addr;
    logic [31:0] idx;
    logic        fault;
    logic        cpu_kill;
    logic        own_ack;

    always_comb begin
        // A flushing CPU cannot be granted; debug may take the slot.
        cpu_ok   = bus.cpu_req && !bus.cpu_flush;
        starved  = bus.dbg_req && (starve_cnt == SMAX);
        sel_dbg  = bus.dbg_req && (starved || !cpu_ok);
        grant    = cpu_ok || bus.dbg_req;
        sel_addr = sel_dbg ? bus.dbg_addr : bus.cpu_addr;
        cpu_kill = (owner == OWN_CPU) && bus.cpu_flush;
        own_ack  = (owner == OWN_CPU) ? bus.cpu_ack
                                      : bus.dbg_ack;
    end

    fetch_addr_xlate #(
        .TEXT_BASE (TEXT_BASE),
        .DEPTH     (DEPTH)
    ) u_xlate (
        .addr  (sel_addr),
        .index (idx),
        .fault (fault)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= OWN_CPU;
            starve_cnt  <= '0;
            imemsrc_q   <= 1'b0;
            imem_pc_q   <= '0;
            cpu_gnt_q   <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            cpu_valid_q <= 1'b0;
            dbg_valid_q <= 1'b0;
            cpu_fault_q <= 1'b0;
            dbg_fault_q <= 1'b0;
        end else begin
            cpu_gnt_q <= 1'b0;
            dbg_gnt_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner     <= sel_dbg ? OWN_DBG : OWN_CPU;
                        cpu_gnt_q <= !sel_dbg;
                        dbg_gnt_q <= sel_dbg;
                        unique case (1'b1)
                            sel_dbg:
                                starve_cnt <= '0;
                            !bus.dbg_req:
                                starve_cnt <= '0;
                            default:
                                if (starve_cnt != SMAX)
                                    starve_cnt <= starve_cnt + SW'(1);
                        endcase
                        // Faults skip the imem read entirely.
                        if (fault) begin
                            state       <= ST_RESP;
                            cpu_valid_q <= !sel_dbg;
                            dbg_valid_q <= sel_dbg;
                            cpu_fault_q <= !sel_dbg;
                            dbg_fault_q <= sel_dbg;
                        end else begin
                            state     <= ST_ISSUE;
                            imemsrc_q <= 1'b1;
                            imem_pc_q <= idx;
                        end
                    end
                end
                ST_ISSUE: begin
                    imemsrc_q <= 1'b0;
                    if (cpu_kill) begin
                        state <= ST_IDLE;
                    end else begin
                        state       <= ST_RESP;
                        cpu_valid_q <= (owner == OWN_CPU);
                        dbg_valid_q <= (owner == OWN_DBG);
                    end
                end
                ST_RESP: begin
                    if (cpu_kill || own_ack) begin
                        state       <= ST_IDLE;
                        cpu_valid_q <= 1'b0;
                        dbg_valid_q <= 1'b0;
                        cpu_fault_q <= 1'b0;
                        dbg_fault_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // imemsrc is low throughout RESP, so imem_inst is stable there.
    assign bus.cpu_inst  = (cpu_valid_q && !cpu_fault_q)
                         ? bus.imem_inst : '0;
    assign bus.dbg_inst  = (dbg_valid_q && !dbg_fault_q)
                         ? bus.imem_inst : '0;
    assign bus.imemsrc   = imemsrc_q;
    assign bus.imem_pc   = imem_pc_q;
    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.dbg_gnt   = dbg_gnt_q;
    assign bus.cpu_valid = cpu_valid_q;
    assign bus.dbg_valid = dbg_valid_q;
    assign bus.cpu_fault = cpu_fault_q;
    assign bus.dbg_fault = dbg_fault_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural imem model.
// Checks reset, latency, hold, faults, arbitration, flush and reset abort.
module tb_imem_fetch_ctrl;

    logic clk;
    logic rst;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:1023];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.imemsrc)
            bus.imem_inst <= mem[bus.imem_pc[9:0]];

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"},
            {24'b0, bus.imemsrc, bus.cpu_gnt, bus.dbg_gnt,
             bus.cpu_valid, bus.dbg_valid, bus.cpu_fault,
             bus.dbg_fault, bus.busy}, 32'h0);
        chk({tag, "_pc"}, bus.imem_pc, 32'h0);
        chk({tag, "_cinst"}, bus.cpu_inst, 32'h0);
        chk({tag, "_dinst"}, bus.dbg_inst, 32'h0);
    endtask

    task automatic fetch(input string tag,
                         input logic [31:0] addr,
                         input logic [31:0] pc,
                         input logic [31:0] inst);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        tick();
        chk({tag, "_src"}, {31'b0, bus.imemsrc}, 32'd1);
        chk({tag, "_pc"}, bus.imem_pc, pc);
        bus.cpu_req = 1'b0;
        tick();
        chk({tag, "_valid"}, {31'b0, bus.cpu_valid}, 32'd1);
        chk({tag, "_inst"}, bus.cpu_inst, inst);
        chk({tag, "_fault"}, {31'b0, bus.cpu_fault}, 32'd0);
        bus.cpu_ack = 1'b1;
        tick();
        chk({tag, "_done"}, {31'b0, bus.cpu_valid}, 32'd0);
        bus.cpu_ack = 1'b0;
    endtask

    task automatic fetch_fault(input string tag,
                               input logic [31:0] addr);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        tick();
        chk({tag, "_valid"}, {31'b0, bus.cpu_valid}, 32'd1);
        chk({tag, "_fault"}, {31'b0, bus.cpu_fault}, 32'd1);
        chk({tag, "_inst"}, bus.cpu_inst, 32'h0);
        chk({tag, "_src"}, {31'b0, bus.imemsrc}, 32'd0);
        bus.cpu_req = 1'b0;
        bus.cpu_ack = 1'b1;
        tick();
        chk({tag, "_done"}, {31'b0, bus.cpu_valid}, 32'd0);
        chk({tag, "_src2"}, {31'b0, bus.imemsrc}, 32'd0);
        bus.cpu_ack = 1'b0;
    endtask

    initial begin
        int ng;
        logic [9:0] exp_dbg;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1]    = 32'h00A0_0093;
        mem[2]    = 32'h2408_0001;
        mem[4]    = 32'h1111_2222;
        mem[1023] = 32'hDEAD_BEEF;

        rst           = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_flush = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.dbg_req   = 1'b0;
        bus.dbg_addr  = 32'h0;
        bus.dbg_ack   = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        // Basic fetch, then hold RESP for 5 cycles.
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0040_0008;
        tick();
        chk("f0_src", {31'b0, bus.imemsrc}, 32'd1);
        chk("f0_pc", bus.imem_pc, 32'd2);
        chk("f0_gnt", {31'b0, bus.cpu_gnt}, 32'd1);
        chk("f0_busy", {31'b0, bus.busy}, 32'd1);
        chk("f0_novalid", {31'b0, bus.cpu_valid}, 32'd0);
        bus.cpu_req = 1'b0;
        tick();
        chk("f0_valid", {31'b0, bus.cpu_valid}, 32'd1);
        chk("f0_inst", bus.cpu_inst, 32'h2408_0001);
        chk("f0_fault", {31'b0, bus.cpu_fault}, 32'd0);
        chk("f0_gnt_off", {31'b0, bus.cpu_gnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", {31'b0, bus.cpu_valid}, 32'd1);
            chk("hold_inst", bus.cpu_inst, 32'h2408_0001);
            chk("hold_src", {31'b0, bus.imemsrc}, 32'd0);
        end
        bus.cpu_ack = 1'b1;
        tick();
        chk("ack_valid", {31'b0, bus.cpu_valid}, 32'd0);
        chk("ack_busy", {31'b0, bus.busy}, 32'd0);
        chk("ack_inst", bus.cpu_inst, 32'h0);
        bus.cpu_ack = 1'b0;

        // Address boundaries.
        fetch_fault("misal", 32'h0040_0002);
        fetch_fault("range", 32'h0040_1000);
        fetch_fault("below", 32'h003F_FFFC);
        fetch("top", 32'h0040_0FFC, 32'd1023, 32'hDEAD_BEEF);

        // Starvation: 4 CPU grants then 1 debug grant, twice.
        exp_dbg      = 10'b10_0001_0000;
        ng           = 0;
        bus.cpu_addr = 32'h0040_0004;
        bus.dbg_addr = 32'h0040_0010;
        bus.cpu_ack  = 1'b1;
        bus.dbg_ack  = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.dbg_req  = 1'b1;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            tick();
            if (bus.cpu_valid)
                chk("arb_cinst", bus.cpu_inst, 32'h00A0_0093);
            if (bus.dbg_valid)
                chk("arb_dinst", bus.dbg_inst, 32'h1111_2222);
            if (bus.cpu_gnt || bus.dbg_gnt) begin
                chk("arb_onehot",
                    {31'b0, bus.cpu_gnt & bus.dbg_gnt}, 32'd0);
                chk($sformatf("arb_gnt%0d", ng),
                    {31'b0, bus.dbg_gnt}, {31'b0, exp_dbg[ng]});
                ng++;
            end
        end
        chk("arb_count", ng, 32'd10);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        for (int c = 0; c < 6 && bus.busy; c++) tick();
        chk("arb_drain", {31'b0, bus.busy}, 32'd0);
        bus.cpu_ack = 1'b0;
        bus.dbg_ack = 1'b0;

        // Flush in ISSUE.
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0040_0008;
        tick();
        chk("fli_src", {31'b0, bus.imemsrc}, 32'd1);
        bus.cpu_req   = 1'b0;
        bus.cpu_flush = 1'b1;
        tick();
        chk("fli_busy", {31'b0, bus.busy}, 32'd0);
        chk("fli_valid", {31'b0, bus.cpu_valid}, 32'd0);
        bus.cpu_flush = 1'b0;
        tick();
        chk("fli_valid2", {31'b0, bus.cpu_valid}, 32'd0);

        // Flush in RESP.
        bus.cpu_req = 1'b1;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        chk("flr_valid", {31'b0, bus.cpu_valid}, 32'd1);
        bus.cpu_flush = 1'b1;
        tick();
        chk("flr_drop", {31'b0, bus.cpu_valid}, 32'd0);
        chk("flr_busy", {31'b0, bus.busy}, 32'd0);

        // Flush in IDLE blocks CPU; debug goes and ignores flush.
        bus.cpu_req  = 1'b1;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 32'h0040_0010;
        tick();
        chk("fl_dgnt", {31'b0, bus.dbg_gnt}, 32'd1);
        chk("fl_cgnt", {31'b0, bus.cpu_gnt}, 32'd0);
        chk("fl_pc", bus.imem_pc, 32'd4);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        tick();
        chk("fl_dvalid", {31'b0, bus.dbg_valid}, 32'd1);
        chk("fl_dinst", bus.dbg_inst, 32'h1111_2222);
        bus.cpu_ack = 1'b1;
        tick();
        chk("xack_dvalid", {31'b0, bus.dbg_valid}, 32'd1);
        chk("xack_cvalid", {31'b0, bus.cpu_valid}, 32'd0);
        bus.cpu_ack   = 1'b0;
        bus.dbg_ack   = 1'b1;
        bus.cpu_flush = 1'b0;
        tick();
        chk("dack_valid", {31'b0, bus.dbg_valid}, 32'd0);
        chk("dack_busy", {31'b0, bus.busy}, 32'd0);
        bus.dbg_ack = 1'b0;

        // Reset during RESP discards the fetch.
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0040_0008;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        chk("rr_valid", {31'b0, bus.cpu_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk_zero("rr");
        rst = 1'b0;
        tick();
        chk("rr_idle", {31'b0, bus.cpu_valid}, 32'd0);
        fetch("post", 32'h0040_0008, 32'd2, 32'h2408_0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
